// File: rtl/shiftr_engine.sv
// Burst shift engine: shift-left/right, rotate-left and Fibonacci LFSR over a counted burst.
// Optional macro SHIFTR_ZERO_GUARD_EN: an all-zero seed loaded with mode 11 becomes 1 to avoid LFSR lock-up.
//
// state | meaning
// IDLE  | waiting for start, no shifting
// SHIFT | one shift per cycle, remaining-shift counter decrements
// DONE  | single cycle completion pulse, then IDLE
module shiftr_engine #(
  parameter int N = 8,
  parameter logic [N-1:0] TAPS = N'('hB8),
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [N-1:0]     seed,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             data,
  output logic [N-1:0]     q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [N-1:0]     Q_ONE   = N'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [1:0]       mode_lat;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     q_shift;
  logic             sout_shift;
  logic             fb;
  logic [N-1:0]     load_val;

  always_comb begin
    fb         = ^(q & TAPS);
    q_shift    = q;
    sout_shift = q[N-1];
    case (mode_lat)
      2'b00: begin
        q_shift    = {q[N-2:0], data};
        sout_shift = q[N-1];
      end
      2'b01: begin
        q_shift    = {data, q[N-1:1]};
        sout_shift = q[0];
      end
      2'b10: begin
        q_shift    = {q[N-2:0], q[N-1]};
        sout_shift = q[N-1];
      end
      default: begin
        q_shift    = {q[N-2:0], fb ^ data};
        sout_shift = q[N-1];
      end
    endcase
  end

  always_comb begin
    load_val = seed;
`ifdef SHIFTR_ZERO_GUARD_EN
    if (mode == 2'b11 && seed == '0) load_val = Q_ONE;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q        <= '0;
      sout     <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      mode_lat <= 2'b00;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (load) begin
      // load aborts any burst silently; sout keeps the last shifted bit
      q     <= load_val;
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_lat <= mode;
            cnt      <= len;
            if (len != '0) begin
              state <= SHIFT;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          q    <= q_shift;
          sout <= sout_shift;
          cnt  <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shiftr_engine.sv
// Bench for shiftr_engine: directed scenarios plus randomized traffic against a behavioural model.
module tb_shiftr_engine;

  logic       clk = 1'b0;
  logic       reset, load, start, data;
  logic [7:0] seed;
  logic [1:0] mode;
  logic [3:0] len;
  logic [7:0] q;
  logic       sout, busy, done;

  int checks = 0;
  int errs   = 0;

  localparam logic [7:0] TAPS = 8'hB8;

  // behavioural model: remaining shifts and a pending-done flag
  logic [7:0] m_q;
  logic       m_sout;
  int         m_rem;
  logic       m_dflag;
  logic [1:0] m_mode;

  shiftr_engine #(.N(8), .TAPS(8'hB8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .load(load), .seed(seed), .mode(mode),
    .start(start), .len(len), .data(data),
    .q(q), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int par;
    if (reset) begin
      m_q = 8'h00; m_sout = 1'b0; m_rem = 0; m_dflag = 1'b0; m_mode = 2'b00;
    end else if (load) begin
      m_q = seed;
`ifdef SHIFTR_ZERO_GUARD_EN
      if (mode == 2'b11 && seed == 8'h00) m_q = 8'h01;
`endif
      m_rem = 0; m_dflag = 1'b0;
    end else if (m_rem > 0) begin
      case (m_mode)
        2'b00: begin m_sout = m_q[7]; m_q = 8'((m_q << 1) | 8'(data)); end
        2'b01: begin m_sout = m_q[0]; m_q = 8'((m_q >> 1) | (8'(data) << 7)); end
        2'b10: begin m_sout = m_q[7]; m_q = 8'((m_q << 1) | (m_q >> 7)); end
        default: begin
          par    = $countones(m_q & TAPS) % 2;
          m_sout = m_q[7];
          m_q    = 8'((m_q << 1) | 8'(par[0] ^ data));
        end
      endcase
      m_rem--;
      if (m_rem == 0) m_dflag = 1'b1;
    end else if (m_dflag) begin
      m_dflag = 1'b0;
    end else if (start) begin
      m_mode  = mode;
      m_rem   = int'(len);
      m_dflag = (len == 4'd0);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_val("q",    32'(q),    32'(m_q));
    check_val("sout", 32'(sout), 32'(m_sout));
    check_val("busy", 32'(busy), 32'(m_rem > 0));
    check_val("done", 32'(done), 32'(m_dflag));
  endtask

  task automatic do_load(input logic [7:0] s, input logic [1:0] md);
    load = 1'b1; seed = s; mode = md; start = 1'b0;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_guard;
    int done_seen;
    reset = 1'b1; load = 1'b0; start = 1'b0; data = 1'b0;
    seed = 8'h00; mode = 2'b00; len = 4'd0;
    m_q = 8'h00; m_sout = 1'b0; m_rem = 0; m_dflag = 1'b0; m_mode = 2'b00;

    // reset with other inputs toggling
    for (int i = 0; i < 4; i++) begin
      load = 1'($urandom); start = 1'($urandom); data = 1'($urandom);
      seed = 8'($urandom); mode = 2'($urandom); len = 4'($urandom);
      cyc();
    end
    check_val("rst_q", 32'(q), 32'h00);
    check_val("rst_sout", 32'(sout), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_done", 32'(done), 0);
    reset = 1'b0; load = 1'b0; start = 1'b1; len = 4'd0;
    cyc();
    start = 1'b0;
    check_val("len0_done", 32'(done), 1);
    check_val("len0_busy", 32'(busy), 0);
    cyc();
    check_val("len0_done_end", 32'(done), 0);

    // shift-left with data=1
    data = 1'b1;
    do_load(8'hA5, 2'b00);
    start = 1'b1; len = 4'd4;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("sl_busy", 32'(busy), 1);
      cyc();
    end
    check_val("sl_busy_last", 32'(busy), 1);
    cyc();
    check_val("sl_q", 32'(q), 32'h5F);
    check_val("sl_sout", 32'(sout), 0);
    check_val("sl_done", 32'(done), 1);
    check_val("sl_busy_off", 32'(busy), 0);
    cyc();
    check_val("sl_done_off", 32'(done), 0);

    // shift-right single shift
    data = 1'b0;
    do_load(8'h81, 2'b01);
    start = 1'b1; len = 4'd1;
    cyc();
    start = 1'b0;
    cyc();
    check_val("sr_q", 32'(q), 32'h40);
    check_val("sr_sout", 32'(sout), 1);
    check_val("sr_done", 32'(done), 1);
    cyc();

    // rotate-left, mode/data toggled mid-burst
    do_load(8'h81, 2'b10);
    start = 1'b1; len = 4'd3;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data = 1'($urandom); mode = 2'($urandom);
      cyc();
    end
    check_val("rot_q", 32'(q), 32'h0C);
    check_val("rot_done", 32'(done), 1);
    cyc();

    // LFSR PRBS from 0x80
    data = 1'b0;
    do_load(8'h80, 2'b11);
    start = 1'b1; len = 4'd2;
    cyc();
    start = 1'b0;
    cyc();
    check_val("lfsr_e1", 32'(q), 32'h01);
    cyc();
    check_val("lfsr_e2", 32'(q), 32'h02);
    check_val("lfsr_sout", 32'(sout), 0);
    cyc();

    // abort with load at E3
    do_load(8'h11, 2'b00);
    start = 1'b1; len = 4'd10;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    load = 1'b1; seed = 8'h3C;
    cyc();
    load = 1'b0;
    check_val("abort_q", 32'(q), 32'h3C);
    check_val("abort_busy", 32'(busy), 0);
    check_val("abort_done", 32'(done), 0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (done) done_seen++;
    end
    check_val("abort_no_done", 32'(done_seen), 0);

    // zero seed in LFSR mode
`ifdef SHIFTR_ZERO_GUARD_EN
    exp_guard = 8'h01;
`else
    exp_guard = 8'h00;
`endif
    data = 1'b0;
    do_load(8'h00, 2'b11);
    check_val("guard_q", 32'(q), 32'(exp_guard));
    start = 1'b1; len = 4'd8;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
`ifndef SHIFTR_ZERO_GUARD_EN
    check_val("lockup_q", 32'(q), 32'h00);
`endif
    check_val("lockup_done", 32'(done), 1);
    cyc();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      load  = ($urandom_range(0, 19) == 0);
      start = ($urandom_range(0, 2) == 0);
      seed  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      mode  = 2'($urandom);
      len   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
      data  = 1'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
